// File: rtl/shared_timer_arbiter_pkg.sv
// Shared definitions for the shared timer arbiter: FSM state encoding and default sizes.
package shared_timer_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shared_timer_arbiter_if.sv
// Requester-side bus of the shared timer arbiter.
// The aborted pulse exists only when SHARED_TIMER_ABORT_EN is defined.
interface shared_timer_arbiter_if
  import shared_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]       done;
`ifdef SHARED_TIMER_ABORT_EN
  logic [NUM_REQ-1:0]       aborted;

  modport master (output req, len, input grant, busy, count, done, aborted);
  modport slave  (input req, len, output grant, busy, count, done, aborted);
`else
  modport master (output req, len, input grant, busy, count, done);
  modport slave  (input req, len, output grant, busy, count, done);
`endif

endinterface

// File: rtl/shared_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req strictly after last_grant, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] winner
);

  int                 shift_s;
  logic [NUM_REQ-1:0] rot_s;
  logic [NUM_REQ-1:0] low_s;

  // Rotate so the slot after last_grant sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    shift_s = 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      shift_s = last_grant[i] ? (i + 1) : shift_s;
    end
    rot_s  = NUM_REQ'({req, req} >> shift_s);
    low_s  = rot_s & (~rot_s + NUM_REQ'(1));
    winner = NUM_REQ'(({low_s, low_s} << shift_s) >> NUM_REQ);
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One shared up-counter granted round-robin; times the owner's latched length, then pulses done.
// Optional owner abort on req drop during RUN is enabled by SHARED_TIMER_ABORT_EN.
module shared_timer_arbiter
  import shared_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  shared_timer_arbiter_if.slave bus
);

  state_t             state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] last_grant_r;
  logic [NUM_REQ-1:0] done_r;
  logic               busy_r;
  logic [WIDTH-1:0]   count_r;
  logic [WIDTH-1:0]   len_r;
  logic [NUM_REQ-1:0] winner_s;
  logic [WIDTH-1:0]   len_sel_s;
`ifdef SHARED_TIMER_ABORT_EN
  logic [NUM_REQ-1:0] aborted_r;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .last_grant (last_grant_r),
    .winner     (winner_s)
  );

  // Length slice belonging to the current arbitration winner.
  always_comb begin
    len_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len_sel_s = len_sel_s | (winner_s[i] ? bus.len[i*WIDTH +: WIDTH] : '0);
    end
  end

  // Timer FSM; done/aborted default low so each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      busy_r       <= 1'b0;
      count_r      <= '0;
      len_r        <= '0;
      done_r       <= '0;
      last_grant_r <= {1'b1, {(NUM_REQ-1){1'b0}}};
`ifdef SHARED_TIMER_ABORT_EN
      aborted_r    <= '0;
`endif
    end else begin
      done_r <= '0;
`ifdef SHARED_TIMER_ABORT_EN
      aborted_r <= '0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (|winner_s) begin
            grant_r <= winner_s;
            busy_r  <= 1'b1;
            len_r   <= len_sel_s;
            count_r <= '0;
            if (len_sel_s == '0) begin
              state_r <= ST_DONE;
              done_r  <= winner_s;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
`ifdef SHARED_TIMER_ABORT_EN
          if ((bus.req & grant_r) == '0) begin
            aborted_r    <= grant_r;
            last_grant_r <= grant_r;
            grant_r      <= '0;
            busy_r       <= 1'b0;
            count_r      <= '0;
            state_r      <= ST_IDLE;
          end else
`endif
          if (count_r == len_r - WIDTH'(1)) begin
            state_r <= ST_DONE;
            done_r  <= grant_r;
          end else begin
            count_r <= count_r + WIDTH'(1);
          end
        end
        ST_DONE: begin
          last_grant_r <= grant_r;
          grant_r      <= '0;
          busy_r       <= 1'b0;
          count_r      <= '0;
          state_r      <= ST_IDLE;
        end
        default: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          count_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant = grant_r;
  assign bus.busy  = busy_r;
  assign bus.count = count_r;
  assign bus.done  = done_r;
`ifdef SHARED_TIMER_ABORT_EN
  assign bus.aborted = aborted_r;
`endif

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Self-checking bench for shared_timer_arbiter: vector table plus directed multi-cycle sequences.
// Covers both builds with and without SHARED_TIMER_ABORT_EN.
module tb_shared_timer_arbiter;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] count;
    logic [3:0]  done;
  } vec_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  shared_timer_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) bus_if ();

  shared_timer_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_grant"}, bus_if.grant, 4'b0000);
    check({name, "_busy"},  bus_if.busy,  1'b0);
    check({name, "_count"}, bus_if.count, 16'd0);
    check({name, "_done"},  bus_if.done,  4'b0000);
`ifdef SHARED_TIMER_ABORT_EN
    check({name, "_aborted"}, bus_if.aborted, 4'b0000);
`endif
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    step();
    check_idle("in_reset");
    clear = 1'b1;
    step();
    check_idle("after_reset");
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus_if.grant == 4'b0000 && n < 10);
    g = bus_if.grant;
  endtask

  task automatic wait_done(output int held);
    held = 1;
    while (bus_if.done == 4'b0000 && held < 10) begin
      step();
      held++;
    end
  endtask

  vec_t vecs[12];
  logic [3:0] exp_order[4];

  initial begin
    logic [3:0]  g;
    int          held;
    logic [15:0] prev;
    logic        mono;

    bus_if.req = 4'b0000;
    bus_if.len = 64'd0;

    // Test 1: reset state
    do_reset();

    // Tests 2 and 4 plus latched-length check as per-cycle vectors
    vecs[0]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 1'b1, 16'd0, 4'b0000};
    vecs[1]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 1'b1, 16'd1, 4'b0000};
    vecs[2]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 1'b1, 16'd2, 4'b0000};
    vecs[3]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 1'b1, 16'd2, 4'b0001};
    vecs[4]  = '{4'b0000, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0000, 1'b0, 16'd0, 4'b0000};
    vecs[5]  = '{4'b0100, {16'd7, 16'd0, 16'd5, 16'd3}, 4'b0100, 1'b1, 16'd0, 4'b0100};
    vecs[6]  = '{4'b0000, {16'd7, 16'd0, 16'd5, 16'd3}, 4'b0000, 1'b0, 16'd0, 4'b0000};
    vecs[7]  = '{4'b0010, {16'd7, 16'd0, 16'd2, 16'd3}, 4'b0010, 1'b1, 16'd0, 4'b0000};
    vecs[8]  = '{4'b0010, {16'd7, 16'd0, 16'd9, 16'd3}, 4'b0010, 1'b1, 16'd1, 4'b0000};
    vecs[9]  = '{4'b0010, {16'd7, 16'd0, 16'd9, 16'd3}, 4'b0010, 1'b1, 16'd1, 4'b0010};
    vecs[10] = '{4'b0000, {16'd7, 16'd0, 16'd9, 16'd3}, 4'b0000, 1'b0, 16'd0, 4'b0000};
    vecs[11] = '{4'b0000, {16'd7, 16'd0, 16'd9, 16'd3}, 4'b0000, 1'b0, 16'd0, 4'b0000};

    for (int i = 0; i < 12; i++) begin
      bus_if.req = vecs[i].req;
      bus_if.len = vecs[i].len;
      step();
      check($sformatf("vec%0d_grant", i), bus_if.grant, vecs[i].grant);
      check($sformatf("vec%0d_busy", i),  bus_if.busy,  vecs[i].busy);
      check($sformatf("vec%0d_count", i), bus_if.count, vecs[i].count);
      check($sformatf("vec%0d_done", i),  bus_if.done,  vecs[i].done);
    end

    // Reset mid-interval drops the interval and restores req0 priority
    bus_if.req = 4'b0001;
    bus_if.len = {16'd1, 16'd1, 16'd1, 16'd5};
    step();
    check("pre_reset_grant", bus_if.grant, 4'b0001);
    bus_if.req = 4'b0000;
    do_reset();

    // Test 3: round-robin order with all requesting, then wrap and no back-to-back re-grant
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    bus_if.req = 4'b1111;
    bus_if.len = {16'd1, 16'd1, 16'd1, 16'd1};
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check($sformatf("rr_order%0d", k), g, exp_order[k]);
      wait_done(held);
      check($sformatf("rr_done%0d", k), bus_if.done, exp_order[k]);
      check($sformatf("rr_held%0d", k), held, 2);
      bus_if.req = bus_if.req & ~exp_order[k];
    end
    bus_if.req = 4'b0001;
    wait_grant(g);
    check("rr_wrap", g, 4'b0001);
    wait_done(held);
    check("rr_wrap_done", bus_if.done, 4'b0001);
    bus_if.req = 4'b0011;
    wait_grant(g);
    check("rr_no_regrant", g, 4'b0010);
    wait_done(held);
    bus_if.req = 4'b0000;
    step();
    step();
    check_idle("rr_end");

    // Test 5: maximum length, count peaks at FFFE without wrapping
    bus_if.req = 4'b0001;
    bus_if.len = {16'd1, 16'd1, 16'd1, 16'hFFFF};
    step();
    check("max_grant", bus_if.grant, 4'b0001);
    held = 1;
    prev = bus_if.count;
    mono = 1'b1;
    while (bus_if.done == 4'b0000 && held < 70000) begin
      step();
      held++;
      if (bus_if.count < prev) mono = 1'b0;
      prev = bus_if.count;
    end
    check("max_done", bus_if.done, 4'b0001);
    check("max_count", bus_if.count, 16'hFFFE);
    check("max_held", held, 65536);
    check("max_monotonic", mono, 1'b1);
    bus_if.req = 4'b0000;
    step();
    check_idle("max_end");

    // Test 6: owner drops req mid-interval
    bus_if.req = 4'b0001;
    bus_if.len = {16'd1, 16'd1, 16'd2, 16'd10};
    step();
    check("drop_grant", bus_if.grant, 4'b0001);
    held = 0;
    while (bus_if.count != 16'd4 && held < 20) begin
      step();
      held++;
    end
    check("drop_count4", bus_if.count, 16'd4);
    bus_if.req = 4'b0010;
`ifdef SHARED_TIMER_ABORT_EN
    step();
    check("abort_pulse", bus_if.aborted, 4'b0001);
    check("abort_grant", bus_if.grant, 4'b0000);
    check("abort_count", bus_if.count, 16'd0);
    check("abort_no_done", bus_if.done, 4'b0000);
    step();
    check("abort_next_grant", bus_if.grant, 4'b0010);
    check("abort_pulse_end", bus_if.aborted, 4'b0000);
`else
    wait_done(held);
    check("noabort_done", bus_if.done, 4'b0001);
    check("noabort_count", bus_if.count, 16'd9);
    step();
    check("noabort_release", bus_if.grant, 4'b0000);
    step();
    check("noabort_next_grant", bus_if.grant, 4'b0010);
`endif
    wait_done(held);
    check("next_done", bus_if.done, 4'b0010);
    bus_if.req = 4'b0000;
    step();
    step();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
